// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data memory between the CPU and EXT ports with a fixed-latency access sequence
module dmem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              StallM,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(MAX_CPU_BURST + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t            r_state, w_state_nx;
  logic [SW-1:0]     r_streak;
  logic [1:0]        r_cnt;
  logic              r_own_ext;
  logic [DATA_W-1:0] r_rdata;
  logic              w_sat, w_grant, w_grant_ext, w_last;
  assign cpu_rdata = r_rdata;
  assign ext_rdata = r_rdata;
  assign StallM    = cpu_req & ~cpu_ack;
  // arbitration decision and next-state sequencing
  always_comb begin
    w_state_nx  = r_state;
    w_sat       = r_streak == SW'(MAX_CPU_BURST);
    w_grant     = r_state == IDLE && (cpu_req || ext_req);
    w_grant_ext = ext_req && (!cpu_req || w_sat);
    w_last      = r_state == WAIT && r_cnt == 2'd0;
    case (r_state)
      IDLE:    w_state_nx = w_grant ? ISSUE : IDLE;
      ISSUE:   w_state_nx = WAIT;
      WAIT:    w_state_nx = w_last ? ACK : WAIT;
      default: w_state_nx = IDLE;
    endcase
  end
  // state register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  // access registers, wait counter, fairness streak, read capture and acks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      r_rdata   <= '0;
      r_streak  <= '0;
      r_cnt     <= '0;
      r_own_ext <= 1'b0;
    end else begin
      mem_en  <= w_grant;
      cpu_ack <= w_last && !r_own_ext;
      ext_ack <= w_last && r_own_ext;
      if (w_grant) begin
        r_own_ext <= w_grant_ext;
        mem_we    <= w_grant_ext ? ext_we : cpu_we;
        mem_addr  <= w_grant_ext ? ext_addr : cpu_addr;
        mem_wdata <= w_grant_ext ? ext_wdata : cpu_wdata;
        r_streak  <= (w_grant_ext || !ext_req) ? '0 : w_sat ? r_streak : r_streak + 1'b1;
      end
      if (r_state == ISSUE) r_cnt <= 2'(MEM_LAT - 1);
      else if (r_state == WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (w_last && !mem_we) r_rdata <= mem_rdata;
    end
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and access sequencer for the single-ported data memory. It shares the memory between the pipeline's memory stage (CPU port) and an external loader/debug port (EXT port). Each granted access runs through a fixed-latency issue/wait/acknowledge sequence. While a CPU access is outstanding, the block drives a stall to the pipeline.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..4
- MAX_CPU_BURST, 4, consecutive contended CPU grants allowed before EXT is forced in; legal range ≥1

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle
- cpu_ack  out  1  one-cycle completion pulse
- StallM  out  1  pipeline stall, = cpu_req & ~cpu_ack
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  EXT request fields, same rules as CPU
- ext_rdata  out  DATA_W  read data; valid in the ext_ack cycle
- ext_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered access address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states:
  - IDLE: if any request is pending, latch the winner's we/addr/wdata into the mem_* registers, record the owner, and go to ISSUE.
  - ISSUE: mem_en=1 for exactly one cycle; load wait counter with MEM_LAT-1; go to WAIT.
  - WAIT: lasts MEM_LAT cycles. On the last WAIT cycle, a read captures mem_rdata into the shared rdata register. Writes leave the register unchanged. Then go to ACK.
  - ACK: assert the owner's ack for one cycle, then go to IDLE. No new grant is taken in ACK, so a still-high req is never re-granted.
- Arbitration in IDLE:
  - Only one requester: grant it.
  - Both requesting: CPU wins unless cpu_streak == MAX_CPU_BURST, in which case EXT wins.
- cpu_streak (saturating at MAX_CPU_BURST):
  - increments on a CPU grant while ext_req=1;
  - clears to 0 on a CPU grant with ext_req=0;
  - clears to 0 on any EXT grant.
- cpu_rdata and ext_rdata are both driven from the shared rdata register. Contents are meaningful only during the matching ack.
- Protocol violation: if req drops before its ack, the access still completes and the ack still pulses. No abort.
- Reset (rst=0, asynchronous, including mid-access):
  - state→IDLE, cpu_streak→0;
  - mem_en, mem_we, cpu_ack, ext_ack→0;
  - mem_addr, mem_wdata, rdata→0;
  - the in-flight access is abandoned with no ack.
  - StallM follows cpu_req after reset release.

## Timing
- Request sampled in IDLE at cycle T:
  - mem_en high in T+1;
  - WAIT spans T+2..T+1+MEM_LAT;
  - ack in T+2+MEM_LAT.
- Request-to-ack latency is MEM_LAT+2 cycles. With MEM_LAT=1 that is 3 cycles.
- Back-to-back accesses: the next grant is sampled in the cycle after ACK. Peak throughput is one access per MEM_LAT+3 cycles.
- All outputs are registered except StallM, which is combinational from cpu_req and the cpu_ack register.
- mem_addr, mem_wdata and mem_we hold their values from ISSUE until the next grant.

## Test plan
- CPU read, MEM_LAT=1, memory returns 0xDEADBEEF for addr 0x40; cpu_req at cycle 0 → mem_en in cycle 1 with mem_addr=0x40, cpu_ack plus cpu_rdata=0xDEADBEEF in cycle 3, StallM=1 in cycles 0–2 and 0 in cycle 3.
- EXT write 0x12345678 to 0x80, then CPU read of 0x80 → exactly one mem_en with mem_we=1, ext_ack pulse; the CPU read returns 0x12345678; no ack goes to the wrong port.
- cpu_req and ext_req held high continuously, MAX_CPU_BURST=4 → grant order C,C,C,C,E,C,C,C,C,E; exactly one mem_en per ack.
- Simultaneous first requests with ext_req=0 history → CPU granted first, cpu_streak=1 afterward.
- MEM_LAT=3, CPU read at cycle 0 → mem_en in cycle 1, cpu_ack in cycle 5; rdata captured from the mem_rdata presented in cycle 4.
- rst driven low during WAIT of an EXT read → outputs 0 immediately with no ext_ack. After release, pending cpu_req is granted from IDLE with normal latency.
